instr_fetch_unit: RTL and testbench

- Front end of the SimpleCPU pipeline; it is the writer side of the IF/ID stage register.
- Holds the program counter and requests 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction with its PC and generates the IF/ID write enable.
- Honours pipeline stall and branch/jump redirect from downstream.

---
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack handshake and
// writes the IF/ID stage register. Handles pipeline stall and branch/jump redirect.
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSN_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  output logic              insn_valid,
  output logic              ifid_we
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  state_t          state, next_state;
  logic [PC_W-1:0] pc;

  // The request address is always the PC register itself.
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Redirect overrides everything once we have left IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  next_state = WAIT;
      WAIT:  begin
        if (redirect)      next_state = WAIT;
        else if (imem_ack) next_state = VALID;
      end
      VALID: begin
        if (redirect)      next_state = WAIT;
        else if (!stall)   next_state = WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      insn       <= '0;
      insn_pc    <= '0;
      imem_req   <= 1'b0;
      insn_valid <= 1'b0;
    end else begin
      imem_req   <= (next_state == WAIT);
      insn_valid <= (next_state == VALID);
      if (state != IDLE && redirect) begin
        pc <= redirect_pc;
      end else if (state == WAIT && imem_ack) begin
        insn    <= imem_rdata;
        insn_pc <= pc;
        pc      <= pc + PC_W'(1);
      end
    end
  end

  // A redirect in the same cycle kills the write so a stale instruction never lands.
  always_comb begin
    ifid_we = insn_valid & ~stall & ~redirect;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table of inputs and
// hand-computed outputs, plus hand-written reset sequences.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam int PC_W   = 8;
  localparam int INSN_W = 16;
  localparam int NVEC   = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [INSN_W-1:0] insn;
  logic [PC_W-1:0]   insn_pc;
  logic              insn_valid;
  logic              ifid_we;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   rpc;
    logic              ack;
    logic [INSN_W-1:0] rdata;
    logic              e_req;
    logic [PC_W-1:0]   e_addr;
    logic              e_valid;
    logic [INSN_W-1:0] e_insn;
    logic [PC_W-1:0]   e_ipc;
    logic              e_we;
  } vec_t;

  vec_t vecs [NVEC];

  instr_fetch_unit #(.PC_W(PC_W), .INSN_W(INSN_W), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .insn        (insn),
    .insn_pc     (insn_pc),
    .insn_valid  (insn_valid),
    .ifid_we     (ifid_we)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, actual, expected);
    end
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    compare("imem_req",   idx, 32'(imem_req),   32'(v.e_req));
    compare("imem_addr",  idx, 32'(imem_addr),  32'(v.e_addr));
    compare("insn_valid", idx, 32'(insn_valid), 32'(v.e_valid));
    compare("insn",       idx, 32'(insn),       32'(v.e_insn));
    compare("insn_pc",    idx, 32'(insn_pc),    32'(v.e_ipc));
    compare("ifid_we",    idx, 32'(ifid_we),    32'(v.e_we));
  endtask

  // Drive one cycle's inputs just after the falling edge, check, then move on.
  task automatic applyStimulus(input int idx, input vec_t v);
    stall       = v.stall;
    redirect    = v.redirect;
    redirect_pc = v.rpc;
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    #1;
    checkOutput(idx, v);
    @(negedge clk);
  endtask

  initial begin
    //             stall rdr rpc    ack rdata     req addr   vld insn      ipc    we
    vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA000, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 16'hA000, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA001, 1'b1, 8'h01, 1'b0, 16'hA000, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 16'hA001, 8'h01, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA002, 1'b1, 8'h02, 1'b0, 16'hA001, 8'h01, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b1, 16'hA002, 8'h02, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA003, 1'b1, 8'h03, 1'b0, 16'hA002, 8'h02, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h04, 1'b1, 16'hA003, 8'h03, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h04, 1'b0, 16'hA003, 8'h03, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h04, 1'b0, 16'hA003, 8'h03, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h04, 1'b0, 16'hA003, 8'h03, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, 8'h04, 1'b0, 16'hA003, 8'h03, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 16'h1234, 8'h04, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 16'h1234, 8'h04, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 16'h1234, 8'h04, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 16'h1234, 8'h04, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h05, 1'b1, 16'h1234, 8'h04, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 8'h40, 1'b1, 16'hDEAD, 1'b1, 8'h05, 1'b0, 16'h1234, 8'h04, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hB040, 1'b1, 8'h40, 1'b0, 16'h1234, 8'h04, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h41, 1'b1, 16'hB040, 8'h40, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hB041, 1'b1, 8'h41, 1'b0, 16'hB040, 8'h40, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 8'h10, 1'b0, 16'h0000, 1'b0, 8'h42, 1'b1, 16'hB041, 8'h41, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b1, 8'h10, 1'b0, 16'hB041, 8'h41, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hC0FF, 1'b1, 8'hFF, 1'b0, 16'hB041, 8'h41, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'hC0FF, 8'hFF, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 16'hC0FF, 8'hFF, 1'b0};

    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    #12;
    compare("rst_req",   -1, 32'(imem_req),   32'h0);
    compare("rst_addr",  -1, 32'(imem_addr),  32'h0);
    compare("rst_valid", -1, 32'(insn_valid), 32'h0);
    compare("rst_insn",  -1, 32'(insn),       32'h0);
    compare("rst_ipc",   -1, 32'(insn_pc),    32'h0);
    compare("rst_we",    -1, 32'(ifid_we),    32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

    // Asynchronous reset in the middle of an outstanding fetch.
    imem_ack = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    compare("pre_arst_req", 100, 32'(imem_req), 32'h1);
    rst = 1'b1;
    #1;
    compare("arst_req",   101, 32'(imem_req),   32'h0);
    compare("arst_valid", 101, 32'(insn_valid), 32'h0);
    compare("arst_addr",  101, 32'(imem_addr),  32'h0);
    compare("arst_insn",  101, 32'(insn),       32'h0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare("idle_req", 102, 32'(imem_req), 32'h0);
    @(negedge clk);
    #1;
    compare("refetch_req",  103, 32'(imem_req),  32'h1);
    compare("refetch_addr", 103, 32'(imem_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
